// File: rtl/ryu_anim_fsm.sv
// Ryu animation/action state machine: turns movement flags and punch/kick keys into pose, frame and attack window.
// Optional build macro RYU_AIR_ATTACK_EN lets attacks start from JUMP and return to JUMP on completion.
module ryu_anim_fsm #(
   parameter int unsigned FRAME_HOLD         = 6,
   parameter int unsigned IDLE_FRAMES        = 4,
   parameter int unsigned WALK_FRAMES        = 5,
   parameter int unsigned JUMP_FRAMES        = 4,
   parameter int unsigned PUNCH_FRAMES       = 3,
   parameter int unsigned KICK_FRAMES        = 5,
   parameter int unsigned PUNCH_ACTIVE_FRAME = 1,
   parameter int unsigned KICK_ACTIVE_FRAME  = 2,
   parameter int unsigned HITSTUN_TICKS      = 20
) (
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode_0,
   input  logic [7:0] keycode_1,
   input  logic [7:0] keycode_2,
   input  logic [7:0] keycode_3,
   input  logic       RyuJump,
   input  logic       RyuCrouch,
   input  logic       RyuLeft,
   input  logic       RyuRight,
   input  logic       Ryu_Hit,
   output logic [2:0] RyuPose,
   output logic [2:0] RyuFrame,
   output logic       RyuAttackActive,
   output logic [1:0] RyuAttackType,
   output logic       RyuBusy
);

   localparam int unsigned MAX_A      = (IDLE_FRAMES > WALK_FRAMES) ? IDLE_FRAMES : WALK_FRAMES;
   localparam int unsigned MAX_B      = (JUMP_FRAMES > PUNCH_FRAMES) ? JUMP_FRAMES : PUNCH_FRAMES;
   localparam int unsigned MAX_C      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_FRAMES = (MAX_C > KICK_FRAMES) ? MAX_C : KICK_FRAMES;
   localparam int unsigned FRAME_W    = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
   localparam int unsigned HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam int unsigned STUN_W     = (HITSTUN_TICKS > 1) ? $clog2(HITSTUN_TICKS) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WALK_F  = 3'd1,
      WALK_B  = 3'd2,
      CROUCH  = 3'd3,
      JUMP    = 3'd4,
      PUNCH   = 3'd5,
      KICK    = 3'd6,
      HITSTUN = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [STUN_W-1:0]   stun_q, stun_d;
   logic                punchPrev_q, kickPrev_q;
   logic                attackActive_q, attackActive_d;
   logic [1:0]          attackType_q, attackType_d;
   logic                busy_q, busy_d;

   logic   punchNow, kickNow, punchPress, kickPress, attackPress;
   logic   lastHold, attackDone;
   state_t moveState, attackState;

   assign punchNow = (keycode_0 == 8'h0D) | (keycode_1 == 8'h0D) |
                     (keycode_2 == 8'h0D) | (keycode_3 == 8'h0D);
   assign kickNow  = (keycode_0 == 8'h0E) | (keycode_1 == 8'h0E) |
                     (keycode_2 == 8'h0E) | (keycode_3 == 8'h0E);

   // A simultaneous punch and kick press resolves to punch; the kick edge is simply dropped.
   assign punchPress  = punchNow & ~punchPrev_q;
   assign kickPress   = kickNow & ~kickPrev_q & ~punchPress;
   assign attackPress = punchPress | kickPress;
   assign attackState = punchPress ? PUNCH : KICK;

   assign moveState = RyuJump   ? JUMP   :
                      RyuCrouch ? CROUCH :
                      RyuRight  ? WALK_F :
                      RyuLeft   ? WALK_B : IDLE;

   assign lastHold   = (hold_q == HOLD_W'(FRAME_HOLD - 1));
   assign attackDone = lastHold &&
                       (((state_q == PUNCH) && (frame_q == FRAME_W'(PUNCH_FRAMES - 1))) ||
                        ((state_q == KICK)  && (frame_q == FRAME_W'(KICK_FRAMES - 1))));

   // Next state, frame/hold sequencing and the registered output values derived from them.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      stun_d  = '0;

      if (Ryu_Hit) begin
         state_d = HITSTUN;
      end else begin
         case (state_q)
            HITSTUN: if (stun_q == STUN_W'(HITSTUN_TICKS - 1)) state_d = IDLE;
            PUNCH, KICK: begin
               if (attackDone) begin
`ifdef RYU_AIR_ATTACK_EN
                  state_d = RyuJump ? JUMP : IDLE;
`else
                  state_d = IDLE;
`endif
               end
            end
            JUMP: begin
`ifdef RYU_AIR_ATTACK_EN
               state_d = attackPress ? attackState : moveState;
`else
               state_d = moveState;
`endif
            end
            default: state_d = attackPress ? attackState : moveState;
         endcase
      end

      if (Ryu_Hit || (state_d != state_q)) begin
         frame_d = '0;
         hold_d  = '0;
      end else if (lastHold) begin
         hold_d = '0;
         case (state_q)
            IDLE:           frame_d = (frame_q == FRAME_W'(IDLE_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            WALK_F, WALK_B: frame_d = (frame_q == FRAME_W'(WALK_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            JUMP:           frame_d = (frame_q == FRAME_W'(JUMP_FRAMES - 1)) ? frame_q : frame_q + 1'b1;
            PUNCH, KICK:    frame_d = frame_q + 1'b1;
            default:        frame_d = '0;
         endcase
      end else begin
         hold_d = hold_q + 1'b1;
      end

      if (!Ryu_Hit && (state_q == HITSTUN) && (state_d == HITSTUN)) stun_d = stun_q + 1'b1;

      attackType_d   = (state_d == PUNCH) ? 2'd1 : ((state_d == KICK) ? 2'd2 : 2'd0);
      attackActive_d = ((state_d == PUNCH) && (frame_d == FRAME_W'(PUNCH_ACTIVE_FRAME))) ||
                       ((state_d == KICK)  && (frame_d == FRAME_W'(KICK_ACTIVE_FRAME)));
      busy_d         = (state_d == PUNCH) || (state_d == KICK) || (state_d == HITSTUN);
   end

   // State, counters, key history and outputs all update together on each video frame.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q        <= IDLE;
         frame_q        <= '0;
         hold_q         <= '0;
         stun_q         <= '0;
         punchPrev_q    <= 1'b0;
         kickPrev_q     <= 1'b0;
         attackActive_q <= 1'b0;
         attackType_q   <= 2'd0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_q        <= frame_d;
         hold_q         <= hold_d;
         stun_q         <= stun_d;
         punchPrev_q    <= punchNow;
         kickPrev_q     <= kickNow;
         attackActive_q <= attackActive_d;
         attackType_q   <= attackType_d;
         busy_q         <= busy_d;
      end
   end

   assign RyuPose         = state_q;
   assign RyuFrame        = 3'(frame_q);
   assign RyuAttackActive = attackActive_q;
   assign RyuAttackType   = attackType_q;
   assign RyuBusy         = busy_q;

endmodule

// File: tb/tb_ryu_anim_fsm.sv
// Directed scoreboard bench for ryu_anim_fsm: idle loop, punch/kick timing, hitstun, movement priority, jump attacks.
module tb_ryu_anim_fsm;

   logic       Reset, frame_clk;
   logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
   logic       RyuJump, RyuCrouch, RyuLeft, RyuRight, Ryu_Hit;
   logic [2:0] RyuPose, RyuFrame;
   logic       RyuAttackActive, RyuBusy;
   logic [1:0] RyuAttackType;

   typedef struct {
      string      tag;
      logic [2:0] pose;
      logic [2:0] frame;
      logic       act;
      logic [1:0] typ;
      logic       busy;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   ryu_anim_fsm dut (
      .Reset(Reset), .frame_clk(frame_clk),
      .keycode_0(keycode_0), .keycode_1(keycode_1), .keycode_2(keycode_2), .keycode_3(keycode_3),
      .RyuJump(RyuJump), .RyuCrouch(RyuCrouch), .RyuLeft(RyuLeft), .RyuRight(RyuRight),
      .Ryu_Hit(Ryu_Hit), .RyuPose(RyuPose), .RyuFrame(RyuFrame),
      .RyuAttackActive(RyuAttackActive), .RyuAttackType(RyuAttackType), .RyuBusy(RyuBusy)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic applyStimulus(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2,
                                input logic [7:0] k3, input logic jmp, input logic crch,
                                input logic lft, input logic rgt, input logic hit);
      keycode_0 = k0; keycode_1 = k1; keycode_2 = k2; keycode_3 = k3;
      RyuJump = jmp; RyuCrouch = crch; RyuLeft = lft; RyuRight = rgt; Ryu_Hit = hit;
   endtask

   task automatic pushExpect(input string tag, input int pose, input int frame,
                             input int act, input int typ, input int busy);
      exp_t e;
      e.tag = tag; e.pose = 3'(pose); e.frame = 3'(frame);
      e.act = 1'(act); e.typ = 2'(typ); e.busy = 1'(busy);
      sbq.push_back(e);
   endtask

   task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = sbq.pop_front();
         cmp(e.tag, "pose",  8'(RyuPose),         8'(e.pose));
         cmp(e.tag, "frame", 8'(RyuFrame),        8'(e.frame));
         cmp(e.tag, "act",   8'(RyuAttackActive), 8'(e.act));
         cmp(e.tag, "type",  8'(RyuAttackType),   8'(e.typ));
         cmp(e.tag, "busy",  8'(RyuBusy),         8'(e.busy));
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
      checkOutput();
   endtask

   // Hard stop in case something wedges the main sequence.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1;
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      #22;
      pushExpect("reset", 0, 0, 0, 0, 0);
      checkOutput();
      Reset = 1'b0;

      for (int k = 1; k <= 30; k++) begin
         pushExpect("idle", 0, (k / 6) % 4, 0, 0, 0);
         tick();
      end

      // Punch held for 40 ticks, key in slot 2
      applyStimulus(8'h00, 8'h00, 8'h0D, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 40; i++) begin
         if (i <= 18) pushExpect("punch", 5, (i - 1) / 6, int'(((i - 1) / 6) == 1), 1, 1);
         else         pushExpect("punchIdle", 0, ((i - 19) / 6) % 4, 0, 0, 0);
         tick();
      end
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      pushExpect("punchRelease", 0, 3, 0, 0, 0);
      tick();

      // Kick interrupted by a hit, then a second hit ten ticks into the stun
      for (int i = 1; i <= 37; i++) begin
         applyStimulus(8'h0E, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, (i == 8) || (i == 17));
         if (i <= 7)       pushExpect("kick", 6, (i - 1) / 6, 0, 2, 1);
         else if (i <= 36) pushExpect("stun", 7, 0, 0, 0, 1);
         else              pushExpect("stunEnd", 0, 0, 0, 0, 0);
         tick();
      end

      for (int i = 1; i <= 32; i++) begin
         applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 0);
         pushExpect("walkLR", 1, ((i - 1) / 6) % 5, 0, 0, 0);
         tick();
      end
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 1, 0);
         pushExpect("crouch", 3, 0, 0, 0, 0);
         tick();
      end
      for (int i = 1; i <= 24; i++) begin
         applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 1, 1, 0);
         pushExpect("jump", 4, ((i - 1) / 6 > 3) ? 3 : (i - 1) / 6, 0, 0, 0);
         tick();
      end

      // Punch pressed while airborne
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(8'h00, 8'h0D, 8'h00, 8'h00, 1, 1, 1, 1, 0);
`ifdef RYU_AIR_ATTACK_EN
         if (i <= 18) pushExpect("airPunch", 5, (i - 1) / 6, int'(((i - 1) / 6) == 1), 1, 1);
         else         pushExpect("airReturn", 4, 0, 0, 0, 0);
`else
         pushExpect("airIgnore", 4, 3, 0, 0, 0);
`endif
         tick();
      end
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      pushExpect("land", 0, 0, 0, 0, 0);
      tick();

      // J and K rise together, then K re-pressed mid-punch
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(8'h0D, ((i == 1) || (i >= 4)) ? 8'h0E : 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
         if (i <= 18) pushExpect("punchWins", 5, (i - 1) / 6, int'(((i - 1) / 6) == 1), 1, 1);
         else         pushExpect("punchWinsIdle", 0, 0, 0, 0, 0);
         tick();
      end
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      pushExpect("keysUp", 0, 0, 0, 0, 0);
      tick();

      // Complete kick, key in slot 3
      for (int i = 1; i <= 31; i++) begin
         applyStimulus(8'h00, 8'h00, 8'h00, (i == 1) ? 8'h0E : 8'h00, 0, 0, 0, 0, 0);
         if (i <= 30) pushExpect("kickFull", 6, (i - 1) / 6, int'(((i - 1) / 6) == 2), 2, 1);
         else         pushExpect("kickDone", 0, 0, 0, 0, 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
